// File: rtl/operand_mux_pipe_if.sv
// Purpose: handshake bundle between operand sources and the ALU-side operand register.
// Latency: none (signal bundle only).
// Backpressure: carries out_ready back to the mux and per-channel in_ready to the sources.
//
// Ports (as seen by the mux, modport slave):
//   in_data   in   NUM_IN*WIDTH  packed signed sources, channel i = in_data[i*WIDTH +: WIDTH]
//   in_valid  in   NUM_IN        per-channel source valid
//   in_ready  out  NUM_IN        per-channel accept, at most one bit high
//   sel       in   SEL_W         explicit source index
//   rr_mode   in   1             round-robin request (only honoured with MUX_RR_ARB_EN)
//   out_data  out  WIDTH         registered operand
//   out_valid out  1             out_data holds an unconsumed operand
//   out_ready in   1             consumer takes out_data this cycle
//   out_src   out  SEL_W         channel that produced out_data
//   sel_err   out  1             previous cycle used an out-of-range explicit sel
interface operand_mux_pipe_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4
);
    localparam int SEL_W = $clog2(NUM_IN);

    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic [SEL_W-1:0]        sel;
    logic                    rr_mode;
    logic signed [WIDTH-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [SEL_W-1:0]        out_src;
    logic                    sel_err;

    // Source/consumer side: drives the sources, the select and the consumer ready.
    modport master (
        output in_data,
        output in_valid,
        output sel,
        output rr_mode,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_valid,
        input  out_src,
        input  sel_err
    );

    // Mux side.
    modport slave (
        input  in_data,
        input  in_valid,
        input  sel,
        input  rr_mode,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_valid,
        output out_src,
        output sel_err
    );
endinterface

// File: rtl/operand_mux_pipe.sv
// Purpose: NUM_IN:1 signed operand mux with a registered output stage (explicit sel or, with MUX_RR_ARB_EN, round-robin grant).
// Latency: 1 clk from accept to out_valid; full throughput of 1 word/clk when out_ready stays high.
// Backpressure: while out_valid & !out_ready the output word is held and every in_ready bit is 0.
//
// Ports:
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    operand_mux_pipe_if.slave (sources, select, rr_mode, registered output, sel_err)
// Optional feature macro: MUX_RR_ARB_EN (adds the rr_ptr register and honours bus.rr_mode).
module operand_mux_pipe #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    operand_mux_pipe_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_IN);

    // Output stage registers
    logic signed [WIDTH-1:0] r_out_data;
    logic                    r_out_valid;
    logic [SEL_W-1:0]        r_out_src;
    logic                    r_sel_err;

    // Grant / handshake wires
    logic                    w_space;
    logic                    w_sel_legal;
    logic                    w_rr_act;
    logic [SEL_W-1:0]        w_g;
    logic                    w_g_legal;
    logic [NUM_IN-1:0]       w_in_ready;
    logic                    w_accept;
    logic [WIDTH-1:0]        w_chan;
    logic                    w_sel_err_nxt;

    // The register can take a new word when it is empty or is being drained this cycle.
    assign w_space = !r_out_valid || bus.out_ready;

    // For non-power-of-2 NUM_IN the select field can encode indices with no source behind them.
    assign w_sel_legal = (32'(bus.sel) < NUM_IN);

`ifdef MUX_RR_ARB_EN
    logic [SEL_W-1:0] r_rr_ptr;
    logic [SEL_W-1:0] w_rr_g;
    logic             w_rr_found;

    // Rotating-priority scan: the first valid channel at or after r_rr_ptr wins.
    always_comb begin : p_rr_scan
        int               v_idx;
        logic [SEL_W-1:0] v_sel;
        w_rr_found = 1'b0;
        w_rr_g     = '0;
        v_idx      = 0;
        v_sel      = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            v_idx = int'(r_rr_ptr) + k;
            if (v_idx >= NUM_IN) begin
                v_idx = v_idx - NUM_IN;
            end
            v_sel = SEL_W'(v_idx);
            if (!w_rr_found && bus.in_valid[v_sel]) begin
                w_rr_found = 1'b1;
                w_rr_g     = v_sel;
            end
        end
    end

    // Mode switches take effect on the same cycle's grant.
    assign w_rr_act  = bus.rr_mode;
    assign w_g       = w_rr_act ? w_rr_g : bus.sel;
    assign w_g_legal = w_rr_act ? w_rr_found : w_sel_legal;

    // The pointer only advances on round-robin accepts, so explicit-mode traffic
    // leaves the fairness position where round-robin left it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_accept && w_rr_act) begin
            if (32'(w_g) == NUM_IN - 1) begin
                r_rr_ptr <= '0;
            end else begin
                r_rr_ptr <= w_g + SEL_W'(1);
            end
        end
    end
`else
    // Without the arbiter the mode input has no effect.
    logic w_unused;
    assign w_unused  = bus.rr_mode;
    assign w_rr_act  = 1'b0;
    assign w_g       = bus.sel;
    assign w_g_legal = w_sel_legal;
`endif

    // One-hot ready towards the granted channel only; nothing when the grant is illegal.
    always_comb begin
        w_in_ready = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_g_legal && w_space && (32'(w_g) == i)) begin
                w_in_ready[i] = 1'b1;
            end
        end
    end

    assign w_accept = |(w_in_ready & bus.in_valid);

    // Data select written as a compare loop so an out-of-range index never slices past in_data.
    always_comb begin
        w_chan = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (32'(w_g) == i) begin
                w_chan = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Flag reflects only the most recent cycle; round-robin mode never flags.
    assign w_sel_err_nxt = !w_rr_act && !w_sel_legal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_src   <= '0;
            r_sel_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                // A concurrent out_ready consumes the old word on this same edge.
                r_out_data  <= w_chan;
                r_out_src   <= w_g;
                r_out_valid <= 1'b1;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            r_sel_err <= w_sel_err_nxt;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.out_src   = r_out_src;
    assign bus.sel_err   = r_sel_err;
endmodule

// File: tb/tb_operand_mux_pipe.sv
// Purpose: self-checking bench for operand_mux_pipe (NUM_IN=4 main instance, NUM_IN=3 for illegal-select cases).
// Latency: checks registered outputs 1 clk after each accept.
// Backpressure: drives out_ready low/high and random to exercise hold and same-edge reload.
module tb_operand_mux_pipe;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    operand_mux_pipe_if #(.WIDTH(32), .NUM_IN(4)) bus_a ();
    operand_mux_pipe_if #(.WIDTH(32), .NUM_IN(3)) bus_b ();

    operand_mux_pipe #(.WIDTH(32), .NUM_IN(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    operand_mux_pipe #(.WIDTH(32), .NUM_IN(3)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state for dut_a: the word the output register should hold.
    bit          m_valid;
    logic [31:0] m_data;
    int          m_src;
    bit          m_err;
    int          m_ptr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic bit rr_effective(input logic mode);
        bit r;
        r = 1'b0;
`ifdef MUX_RR_ARB_EN
        r = mode;
`endif
        return r;
    endfunction

    // Grant from the rules: round-robin picks the first valid channel starting at ptr,
    // explicit picks sel if it names a real channel. -1 means no grant.
    function automatic int model_grant(input logic [3:0] v, input int sel, input bit rr, input int ptr);
        if (rr) begin
            for (int k = 0; k < 4; k++) begin
                if (v[(ptr + k) % 4]) return (ptr + k) % 4;
            end
            return -1;
        end
        if (sel >= 4) return -1;
        return sel;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_src   = 0;
        m_err   = 1'b0;
        m_ptr   = 0;
    endtask

    // One clock of dut_a against the model. Called at a negedge with inputs already set.
    task automatic cyc();
        int          g;
        int          sel_i;
        bit          rr;
        bit          space;
        bit          acc;
        bit          ordy;
        logic [3:0]  er;
        logic [31:0] word;
        #1;
        rr    = rr_effective(bus_a.rr_mode);
        sel_i = int'(bus_a.sel);
        ordy  = bus_a.out_ready;
        space = !m_valid || ordy;
        g     = model_grant(bus_a.in_valid, sel_i, rr, m_ptr);
        er    = '0;
        if (g >= 0 && space) er[g] = 1'b1;
        acc   = (g >= 0) && space && bus_a.in_valid[g];
        word  = (g >= 0) ? bus_a.in_data[g*32 +: 32] : 32'h0;
        chk("a_in_ready", 32'(bus_a.in_ready), 32'(er));
        @(posedge clk);
        if (acc) begin
            m_data  = word;
            m_src   = g;
            m_valid = 1'b1;
            if (rr) m_ptr = (g + 1) % 4;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        m_err = !rr && (sel_i >= 4);
        #1;
        chk("a_out_valid", 32'(bus_a.out_valid), 32'(m_valid));
        chk("a_out_data",  bus_a.out_data, m_data);
        chk("a_out_src",   32'(bus_a.out_src), 32'(m_src));
        chk("a_sel_err",   32'(bus_a.sel_err), 32'(m_err));
        @(negedge clk);
    endtask

    // Asynchronous reset: outputs clear before any edge, and no word is taken while held.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 32'(bus_a.out_valid), 32'h0);
        chk("rst_async_data",  bus_a.out_data, 32'h0);
        chk("rst_async_src",   32'(bus_a.out_src), 32'h0);
        chk("rst_async_err",   32'(bus_a.sel_err), 32'h0);
        chk("rst_async_b_vld", 32'(bus_b.out_valid), 32'h0);
        @(posedge clk);
        #1;
        chk("rst_no_accept",   32'(bus_a.out_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic idle_b();
        bus_b.in_data   = '0;
        bus_b.in_valid  = '0;
        bus_b.sel       = '0;
        bus_b.rr_mode   = 1'b0;
        bus_b.out_ready = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        bus_a.in_data   = '0;
        bus_a.in_valid  = '0;
        bus_a.sel       = '0;
        bus_a.rr_mode   = 1'b0;
        bus_a.out_ready = 1'b1;
        idle_b();
        model_reset();
        #1;
        do_reset();

        // Explicit select of a negative operand
        bus_a.in_data   = {32'h3333_3333, 32'hFFFF_FF80, 32'h1111_1111, 32'h0000_0000};
        bus_a.in_valid  = 4'b0100;
        bus_a.sel       = 2'd2;
        bus_a.out_ready = 1'b1;
        cyc();
        chk("t2_data_m128", bus_a.out_data, 32'hFFFF_FF80);
        chk("t2_src",       32'(bus_a.out_src), 32'd2);

        // Backpressure: word held, no ready, for 5 clocks
        bus_a.out_ready = 1'b0;
        bus_a.in_valid  = 4'b0001;
        bus_a.sel       = 2'd0;
        bus_a.in_data[31:0] = 32'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t3_hold_data", bus_a.out_data, 32'hFFFF_FF80);
        end
        bus_a.out_ready = 1'b1;
        cyc();
        chk("t3_reload_data", bus_a.out_data, 32'h1234_5678);
        chk("t3_reload_src",  32'(bus_a.out_src), 32'd0);

        // Streaming with sel cycling, no bubble
        bus_a.in_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            bus_a.sel = 2'(i);
            for (int c = 0; c < 4; c++) bus_a.in_data[c*32 +: 32] = $urandom();
            cyc();
            chk("t4_stream_src",   32'(bus_a.out_src), 32'(i));
            chk("t4_stream_valid", 32'(bus_a.out_valid), 32'h1);
        end

        // NUM_IN=3 instance: out-of-range select
        bus_a.in_valid  = 4'b0000;
        bus_b.in_data   = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
        bus_b.in_valid  = 3'b111;
        bus_b.out_ready = 1'b1;
        bus_b.sel       = 2'd3;
        #1;
        chk("t5_b_ready_none", 32'(bus_b.in_ready), 32'h0);
        cyc();
        chk("t5_b_valid_none", 32'(bus_b.out_valid), 32'h0);
        chk("t5_b_err_set",    32'(bus_b.sel_err), 32'h1);
        bus_b.sel = 2'd1;
        #1;
        chk("t5_b_ready_1", 32'(bus_b.in_ready), 32'h2);
        cyc();
        chk("t5_b_err_clr", 32'(bus_b.sel_err), 32'h0);
        chk("t5_b_valid",   32'(bus_b.out_valid), 32'h1);
        chk("t5_b_src",     32'(bus_b.out_src), 32'h1);
        chk("t5_b_data",    bus_b.out_data, 32'hBBBB_0001);
        idle_b();

`ifndef MUX_RR_ARB_EN
        // Mode input has no effect without the arbiter
        bus_a.rr_mode  = 1'b1;
        bus_a.sel      = 2'd2;
        bus_a.in_valid = 4'b1011;
        #1;
        chk("rr_ignored_ready", 32'(bus_a.in_ready), 32'h4);
        cyc();
        bus_a.rr_mode  = 1'b0;
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            for (int c = 0; c < 4; c++) bus_a.in_data[c*32 +: 32] = $urandom();
            bus_a.in_valid  = 4'($urandom_range(0, 15));
            bus_a.sel       = 2'($urandom_range(0, 3));
            bus_a.rr_mode   = 1'($urandom_range(0, 1));
            bus_a.out_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end

        // Reset mid-stream with a word pending
        bus_a.rr_mode   = 1'b0;
        bus_a.sel       = 2'd1;
        bus_a.in_valid  = 4'b1111;
        bus_a.out_ready = 1'b0;
        cyc();
        chk("mid_pending", 32'(bus_a.out_valid), 32'h1);
        bus_a.out_ready = 1'b1;
        do_reset();

`ifdef MUX_RR_ARB_EN
        // Round-robin grant order and reaction to a dropped request
        bus_a.rr_mode   = 1'b1;
        bus_a.in_valid  = 4'b1011;
        bus_a.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            int exp_src;
            exp_src = (i % 3 == 2) ? 3 : (i % 3);
            for (int c = 0; c < 4; c++) bus_a.in_data[c*32 +: 32] = $urandom();
            cyc();
            chk("t6_rr_src", 32'(bus_a.out_src), 32'(exp_src));
        end
        cyc();
        chk("t6_rr_first0", 32'(bus_a.out_src), 32'd0);
        bus_a.in_valid = 4'b1001;
        cyc();
        chk("t6_rr_skip1", 32'(bus_a.out_src), 32'd3);
        bus_a.rr_mode = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
